// File: rtl/fp_normalize_round.sv
// Iterative normalize-and-round stage: unnormalized sign/exp/magnitude to IEEE-754 binary32 plus RISC-V fflags.
// Define FP_SUBNORMAL_EN to produce correctly rounded subnormals; otherwise tiny results flush to signed zero.
module fp_normalize_round #(
  parameter int unsigned MAX_DENORM_SHIFT = 25
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [10:0] in_exp,
  input  logic [31:0] in_mant,
  input  logic [2:0]  in_frm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_fflags
);

  localparam int unsigned EW = 11;
  localparam int unsigned MW = 32;
  localparam int unsigned CW = $clog2(MAX_DENORM_SHIFT + 1);

`ifdef FP_SUBNORMAL_EN
  localparam bit SubnormEn = 1'b1;
`else
  localparam bit SubnormEn = 1'b0;
`endif

  localparam logic [2:0] FRM_RTZ = 3'b001;
  localparam logic [2:0] FRM_RDN = 3'b010;
  localparam logic [2:0] FRM_RUP = 3'b011;
  localparam logic [2:0] FRM_RMM = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_DENORM, S_ROUND, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic [2:0]            frm_q, frm_d;
  logic                  tiny_q, tiny_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_result_q, out_result_d;
  logic [4:0]            out_fflags_q, out_fflags_d;

  logic                  exp_le0, exp_ge255;
  logic [EW-1:0]         denorm_need;
  logic                  guard, sticky, nx, round_up, ovf_inf;
  logic [30:0]           rounded;

  assign exp_le0     = exp_q[EW-1] || (exp_q == '0);
  assign exp_ge255   = !exp_q[EW-1] && (exp_q >= EW'(255));
  assign denorm_need = EW'(1) - exp_q;

  assign guard   = mant_q[7];
  assign sticky  = |mant_q[6:0];
  assign nx      = guard | sticky;
  // Increment spans the exponent field so carries cross subnormal->normal and frac->exp.
  assign rounded = {exp_q[7:0], mant_q[30:8]} + 31'(round_up);

  // Round-up decision and overflow saturation target by rounding mode; reserved codes act as RNE.
  always_comb begin
    round_up = guard & (sticky | mant_q[8]);
    ovf_inf  = 1'b1;
    case (frm_q)
      FRM_RTZ: begin round_up = 1'b0;                      ovf_inf = 1'b0;    end
      FRM_RDN: begin round_up = sign_q & (guard | sticky);  ovf_inf = sign_q;  end
      FRM_RUP: begin round_up = !sign_q & (guard | sticky); ovf_inf = !sign_q; end
      FRM_RMM: begin round_up = guard;                      ovf_inf = 1'b1;    end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      mant_q       <= '0;
      frm_q        <= '0;
      tiny_q       <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_fflags_q <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      mant_q       <= mant_d;
      frm_q        <= frm_d;
      tiny_q       <= tiny_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_fflags_q <= out_fflags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    mant_d       = mant_q;
    frm_d        = frm_q;
    tiny_d       = tiny_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_fflags_d = out_fflags_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          frm_d   = in_frm;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q[MW-1] || (mant_q == '0)) begin
          tiny_d = exp_le0 && (mant_q != '0);
          // DENORM is unreachable (and pruned) when subnormal support is off.
          if (exp_le0 && (mant_q != '0) && SubnormEn) begin
            cnt_d   = (denorm_need > EW'(MAX_DENORM_SHIFT)) ? CW'(MAX_DENORM_SHIFT) : CW'(denorm_need);
            state_d = S_DENORM;
          end else begin
            state_d = S_ROUND;
          end
        end else begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - EW'(1);
        end
      end
      S_DENORM: begin
        mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          exp_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        out_valid_d = 1'b1;
        state_d     = S_DONE;
        if (mant_q == '0) begin
          out_result_d = {sign_q, 31'h0};
          out_fflags_d = 5'b00000;
        end else if (tiny_q && !SubnormEn) begin
          out_result_d = {sign_q, 31'h0};
          out_fflags_d = 5'b00011;
        end else if (exp_ge255 || (rounded[30:23] == 8'hFF)) begin
          out_result_d = {sign_q, ovf_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
          out_fflags_d = 5'b00101;
        end else begin
          out_result_d = {sign_q, rounded};
          out_fflags_d = {3'b000, tiny_q & nx, nx};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_fflags = out_fflags_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: hand-computed results, flags, latency, reset abort and back-pressure.
module tb_fp_normalize_round;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid, in_ready, in_sign;
  logic [10:0] in_exp;
  logic [31:0] in_mant;
  logic [2:0]  in_frm;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int n_vec = 0;
  int n_err = 0;

  fp_normalize_round dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_frm    (in_frm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_fflags(out_fflags)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Issue one operation at a negedge and follow it through to the DONE handshake.
  task automatic do_op(input string tag, input logic s, input logic [10:0] e, input logic [31:0] m,
                       input logic [2:0] f, input logic [31:0] want_res, input logic [4:0] want_fl,
                       input int want_lat, input int hold, input bit pre_rdy);
    int lat;
    chk_eq({tag, ".rdy"}, 32'(in_ready), 32'd1);
    out_ready = pre_rdy;
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    in_frm    = f;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    chk_eq({tag, ".lat"}, 32'(lat), 32'(want_lat));
    chk_eq({tag, ".res"}, out_result, want_res);
    chk_eq({tag, ".flg"}, 32'(out_fflags), 32'(want_fl));
    chk_eq({tag, ".busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_mant  = 32'hDEAD_BEEF;
      @(posedge CLK);
      @(negedge CLK);
      chk_eq({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
      chk_eq({tag, ".hold_res"}, out_result, want_res);
      chk_eq({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    chk_eq({tag, ".done_vld"}, 32'(out_valid), 32'd0);
    chk_eq({tag, ".done_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    nRST = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_frm = RNE; out_ready = 1'b0;
    #12;
    chk_eq("rst.vld", 32'(out_valid), 32'd0);
    chk_eq("rst.res", out_result, 32'h0);
    chk_eq("rst.flg", 32'(out_fflags), 32'h0);
    chk_eq("rst.rdy", 32'(in_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    do_op("int1",    1'b0, 11'd158, 32'h0000_0001, RNE, 32'h3F80_0000, 5'h00, 33, 0, 1'b0);
    do_op("pow31",   1'b0, 11'd158, 32'h8000_0000, RNE, 32'h4F00_0000, 5'h00, 2, 0, 1'b0);
    do_op("carry_rne", 1'b0, 11'd158, 32'hFFFF_FFFF, RNE, 32'h4F80_0000, 5'h01, 2, 0, 1'b0);
    do_op("carry_rtz", 1'b0, 11'd158, 32'hFFFF_FFFF, RTZ, 32'h4F7F_FFFF, 5'h01, 2, 0, 1'b0);
    do_op("ovf_rup_neg", 1'b1, 11'd300, 32'h8000_0000, RUP, 32'hFF7F_FFFF, 5'h05, 2, 0, 1'b0);
    do_op("ovf_rne_neg", 1'b1, 11'd300, 32'h8000_0000, RNE, 32'hFF80_0000, 5'h05, 2, 0, 1'b0);
    do_op("ovf_rup_pos", 1'b0, 11'd255, 32'h8000_0000, RUP, 32'h7F80_0000, 5'h05, 2, 0, 1'b0);
    do_op("ovf_rdn_pos", 1'b0, 11'd255, 32'h8000_0000, RDN, 32'h7F7F_FFFF, 5'h05, 2, 0, 1'b0);
    do_op("ovf_carry", 1'b0, 11'd254, 32'hFFFF_FFFF, RNE, 32'h7F80_0000, 5'h05, 2, 0, 1'b0);
    do_op("max_rtz",   1'b0, 11'd254, 32'hFFFF_FFFF, RTZ, 32'h7F7F_FFFF, 5'h01, 2, 0, 1'b0);
    do_op("zero_neg",  1'b1, 11'd158, 32'h0000_0000, RNE, 32'h8000_0000, 5'h00, 2, 0, 1'b0);
    do_op("tie_rne",   1'b1, 11'd127, 32'h8000_0080, RNE, 32'hBF80_0000, 5'h01, 2, 0, 1'b0);
    do_op("tie_rdn",   1'b1, 11'd127, 32'h8000_0080, RDN, 32'hBF80_0001, 5'h01, 2, 0, 1'b0);
    do_op("tie_rmm",   1'b0, 11'd127, 32'h8000_0080, RMM, 32'h3F80_0001, 5'h01, 2, 0, 1'b0);
    do_op("frm5_odd",  1'b0, 11'd127, 32'h8000_0180, 3'b101, 32'h3F80_0002, 5'h01, 2, 0, 1'b0);
`ifdef FP_SUBNORMAL_EN
    do_op("tiny",      1'b0, 11'd0,   32'h8000_0000, RNE, 32'h0040_0000, 5'h00, 3, 0, 1'b0);
    do_op("tiny_rnd",  1'b0, 11'h7FF, 32'hFFFF_FFFF, RNE, 32'h0040_0000, 5'h03, 4, 0, 1'b0);
    do_op("tiny_clamp", 1'b0, 11'h670, 32'h8000_0000, RUP, 32'h0000_0001, 5'h03, 27, 0, 1'b0);
`else
    do_op("tiny",      1'b0, 11'd0,   32'h8000_0000, RNE, 32'h0000_0000, 5'h03, 2, 0, 1'b0);
    do_op("tiny_rnd",  1'b1, 11'h7FF, 32'hFFFF_FFFF, RUP, 32'h8000_0000, 5'h03, 2, 0, 1'b0);
    do_op("tiny_clamp", 1'b0, 11'h670, 32'h8000_0000, RUP, 32'h0000_0000, 5'h03, 2, 0, 1'b0);
`endif

    // Abort mid-NORM with an asynchronous reset.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 11'd158; in_mant = 32'h0000_0003; in_frm = RNE;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk_eq("abort.vld", 32'(out_valid), 32'd0);
    chk_eq("abort.rdy", 32'(in_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid === 1'b1) seen = 1;
    end
    chk_eq("abort.quiet", 32'(seen), 32'd0);
    do_op("after_abort", 1'b0, 11'd158, 32'h0000_0003, RNE, 32'h4040_0000, 5'h00, 32, 0, 1'b0);

    do_op("backpress", 1'b0, 11'd158, 32'h8000_0000, RNE, 32'h4F00_0000, 5'h00, 2, 10, 1'b0);
    do_op("pre_ready", 1'b0, 11'd158, 32'h0000_0003, RTZ, 32'h4040_0000, 5'h00, 32, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
